// File: rtl/chip_check_pkg.sv
// Shared types and constants for the chip_74xx result reporter: FSM states and the
// active-low 7-segment glyph table (segment order gfedcba).
package chip_check_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHOW    = 2'd2,
        RELEASE = 2'd3
    } rpt_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [n] is the glyph for hex digit n; the first listed entry is digit F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// One hex digit to an active-low 7-segment pattern (gfedcba).
module hex_to_7seg
    import chip_check_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/chip_result_reporter.sv
// Latches the selected tester's pass/fail result, keeps saturating pass/fail tallies,
// and hands a release request back to the tester after a hold time or an operator press.
module chip_result_reporter
    import chip_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Done,
    input  logic             RSLT,
    input  logic             Continue,
    input  logic             ClearCnt,
    output logic             DISP_RSLT,
    output logic             PassLED,
    output logic             FailLED,
    output logic [CNT_W-1:0] PassCnt,
    output logic [CNT_W-1:0] FailCnt,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    rpt_state_t    state;
    logic [TW-1:0] timer;
    logic          cont_prev;
    logic          armed;      // Done has been seen low since the last capture or reset
    logic          cont_edge;

    assign cont_edge = Continue & ~cont_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            DISP_RSLT <= 1'b0;
            PassLED   <= 1'b0;
            FailLED   <= 1'b0;
            PassCnt   <= '0;
            FailCnt   <= '0;
            timer     <= '0;
            cont_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cont_prev <= Continue;
            DISP_RSLT <= 1'b0;
            if (!Done) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (Done && armed) begin
                        state <= CAPTURE;
                        armed <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (Done) begin
                        PassLED <= RSLT;
                        FailLED <= ~RSLT;
                        if (RSLT && PassCnt != CNT_MAX) PassCnt <= PassCnt + 1'b1;
                        if (!RSLT && FailCnt != CNT_MAX) FailCnt <= FailCnt + 1'b1;
                        timer <= '0;
                        state <= SHOW;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHOW: begin
                    if (!Done) begin
                        state <= IDLE;
                    end else if (timer == TIMER_LAST || cont_edge) begin
                        state     <= RELEASE;
                        DISP_RSLT <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!Done) state <= IDLE;
                    else DISP_RSLT <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Placed last so a clear coinciding with a capture wins.
            if (ClearCnt) begin
                PassCnt <= '0;
                FailCnt <= '0;
            end
        end
    end

    logic [7:0] pass_byte, fail_byte;
    assign pass_byte = 8'(PassCnt);
    assign fail_byte = 8'(FailCnt);

    hex_to_7seg u_hex3 (.digit(pass_byte[7:4]), .seg(HEX3));
    hex_to_7seg u_hex2 (.digit(pass_byte[3:0]), .seg(HEX2));
    hex_to_7seg u_hex1 (.digit(fail_byte[7:4]), .seg(HEX1));
    hex_to_7seg u_hex0 (.digit(fail_byte[3:0]), .seg(HEX0));

endmodule
